// File: rtl/ahb_master_if.sv
// AHB-Lite burst master: turns one user command into a SINGLE/INCR/WRAP burst.
// One command is in flight at a time; ERROR responses abort the burst.
module ahb_master_if #(
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned AHB_ADDR_WIDTH = 32
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [AHB_ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic                      cmd_write_in,
  input  logic [2:0]                cmd_size_in,
  input  logic [2:0]                cmd_burst_in,
  input  logic [AHB_DATA_WIDTH-1:0] wdata_in,
  output logic                      wdata_ready_out,
  output logic [AHB_DATA_WIDTH-1:0] rdata_out,
  output logic                      rdata_valid_out,
  output logic                      done_out,
  output logic                      error_out,
  output logic [AHB_ADDR_WIDTH-1:0] ahb_addr_out,
  output logic [1:0]                ahb_trans_out,
  output logic [2:0]                ahb_burst_out,
  output logic [2:0]                ahb_size_out,
  output logic                      ahb_write_out,
  output logic [AHB_DATA_WIDTH-1:0] ahb_wdata_out,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_rdata_in,
  input  logic                      ahb_ready_in,
  input  logic                      ahb_resp_in
);
  localparam int unsigned DW = AHB_DATA_WIDTH;
  localparam int unsigned AW = AHB_ADDR_WIDTH;
  localparam int unsigned BW = 5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA_LAST, ST_ERR} state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beats_q, beats_d;
  logic           dpend_q, dpend_d;
  logic [AW-1:0]  addr_d;
  logic [1:0]     trans_d;
  logic [2:0]     burst_d, size_d;
  logic           write_d;
  logic [DW-1:0]  wdata_d, rdata_d;
  logic           rvalid_d, done_d, err_d;

  function automatic logic [BW-1:0] burst_len(input logic [2:0] burst);
    case (burst[2:1])
      2'd0:    return BW'(1);
      2'd1:    return BW'(4);
      2'd2:    return BW'(8);
      default: return BW'(16);
    endcase
  endfunction

  // WRAP bursts keep the bits above the wrap span and roll the low bits over
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                              input logic [2:0]    size,
                                              input logic [2:0]    burst);
    logic [AW-1:0] step;
    logic [AW-1:0] mask;
    logic [AW-1:0] incr;
    step = AW'(1) << size;
    mask = (AW'(burst_len(burst)) << size) - AW'(1);
    incr = addr + step;
    if (!burst[0] && (burst != 3'd0)) return (addr & ~mask) | (incr & mask);
    return incr;
  endfunction

  // Command legality: beat wider than the bus, misaligned start, INCR across 1 KB
  logic [AW-1:0] cmd_step;
  logic [12:0]   cmd_end;
  logic          size_bad, align_bad, kb_cross, cmd_reject, cmd_fire;

  assign cmd_step   = AW'(1) << cmd_size_in;
  assign size_bad   = (32'(8) << cmd_size_in) > 32'(DW);
  assign align_bad  = (cmd_addr_in & (cmd_step - AW'(1))) != '0;
  assign cmd_end    = 13'(cmd_addr_in[9:0]) + (13'(burst_len(cmd_burst_in)) << cmd_size_in);
  assign kb_cross   = cmd_burst_in[0] && (cmd_end > 13'd1024);
  assign cmd_reject = size_bad || align_bad || kb_cross;
  assign cmd_fire   = cmd_valid_in && cmd_ready_out;

  // Write data is taken in the same cycle the write address phase completes
  assign wdata_ready_out = (state_q == ST_ADDR) && ahb_write_out && ahb_ready_in;

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire && !cmd_reject) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (dpend_q && ahb_resp_in && !ahb_ready_in)  state_d = ST_ERR;
        else if (ahb_ready_in && (beats_q == BW'(1))) state_d = ST_DATA_LAST;
      end
      ST_DATA_LAST: begin
        if (ahb_ready_in)     state_d = ST_IDLE;
        else if (ahb_resp_in) state_d = ST_ERR;
      end
      ST_ERR: begin
        if (ahb_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = ahb_addr_out;
    trans_d  = ahb_trans_out;
    burst_d  = ahb_burst_out;
    size_d   = ahb_size_out;
    write_d  = ahb_write_out;
    wdata_d  = ahb_wdata_out;
    rdata_d  = rdata_out;
    beats_d  = beats_q;
    dpend_d  = dpend_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_reject) begin
            err_d = 1'b1;
          end else begin
            addr_d  = cmd_addr_in;
            size_d  = cmd_size_in;
            burst_d = cmd_burst_in;
            write_d = cmd_write_in;
            trans_d = HTRANS_NONSEQ;
            beats_d = burst_len(cmd_burst_in);
            dpend_d = 1'b0;
          end
        end
      end
      ST_ADDR: begin
        if (dpend_q && ahb_resp_in && !ahb_ready_in) begin
          trans_d = HTRANS_IDLE;
        end else if (ahb_ready_in) begin
          // Previous beat's data phase and this beat's address phase end together
          if (dpend_q && !ahb_write_out) begin
            rdata_d  = ahb_rdata_in;
            rvalid_d = 1'b1;
          end
          if (ahb_write_out) wdata_d = wdata_in;
          dpend_d = 1'b1;
          beats_d = beats_q - BW'(1);
          if (beats_q > BW'(1)) begin
            addr_d  = next_addr(ahb_addr_out, ahb_size_out, ahb_burst_out);
            trans_d = HTRANS_SEQ;
          end else begin
            trans_d = HTRANS_IDLE;
          end
        end
      end
      ST_DATA_LAST: begin
        if (ahb_ready_in) begin
          dpend_d = 1'b0;
          if (ahb_resp_in) begin
            err_d = 1'b1;
          end else begin
            done_d = 1'b1;
            if (!ahb_write_out) begin
              rdata_d  = ahb_rdata_in;
              rvalid_d = 1'b1;
            end
          end
        end
      end
      ST_ERR: begin
        if (ahb_ready_in) begin
          err_d   = 1'b1;
          dpend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
    if (!ahb_rstn_in) begin
      ahb_addr_out    <= '0;
      ahb_trans_out   <= HTRANS_IDLE;
      ahb_burst_out   <= '0;
      ahb_size_out    <= '0;
      ahb_write_out   <= 1'b0;
      ahb_wdata_out   <= '0;
      rdata_out       <= '0;
      rdata_valid_out <= 1'b0;
      done_out        <= 1'b0;
      error_out       <= 1'b0;
      cmd_ready_out   <= 1'b0;
      beats_q         <= '0;
      dpend_q         <= 1'b0;
    end else begin
      ahb_addr_out    <= addr_d;
      ahb_trans_out   <= trans_d;
      ahb_burst_out   <= burst_d;
      ahb_size_out    <= size_d;
      ahb_write_out   <= write_d;
      ahb_wdata_out   <= wdata_d;
      rdata_out       <= rdata_d;
      rdata_valid_out <= rvalid_d;
      done_out        <= done_d;
      error_out       <= err_d;
      cmd_ready_out   <= (state_d == ST_IDLE);
      beats_q         <= beats_d;
      dpend_q         <= dpend_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_if.sv
// Bench for ahb_master_if: table of burst commands against a reactive AHB slave
// model, with a queue of expected read data, plus hand-written reset sequences.
module tb_ahb_master_if;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        ahb_clk_in = 1'b0;
  logic        ahb_rstn_in = 1'b0;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [31:0] cmd_addr_in = '0;
  logic        cmd_write_in = 1'b0;
  logic [2:0]  cmd_size_in = '0;
  logic [2:0]  cmd_burst_in = '0;
  logic [31:0] wdata_in = '0;
  logic        wdata_ready_out;
  logic [31:0] rdata_out;
  logic        rdata_valid_out;
  logic        done_out;
  logic        error_out;
  logic [31:0] ahb_addr_out;
  logic [1:0]  ahb_trans_out;
  logic [2:0]  ahb_burst_out;
  logic [2:0]  ahb_size_out;
  logic        ahb_write_out;
  logic [31:0] ahb_wdata_out;
  logic [31:0] ahb_rdata_in = '0;
  logic        ahb_ready_in = 1'b1;
  logic        ahb_resp_in = 1'b0;

  ahb_master_if #(.AHB_DATA_WIDTH(32), .AHB_ADDR_WIDTH(32)) dut (
    .ahb_clk_in(ahb_clk_in), .ahb_rstn_in(ahb_rstn_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_addr_in(cmd_addr_in), .cmd_write_in(cmd_write_in),
    .cmd_size_in(cmd_size_in), .cmd_burst_in(cmd_burst_in),
    .wdata_in(wdata_in), .wdata_ready_out(wdata_ready_out),
    .rdata_out(rdata_out), .rdata_valid_out(rdata_valid_out),
    .done_out(done_out), .error_out(error_out),
    .ahb_addr_out(ahb_addr_out), .ahb_trans_out(ahb_trans_out),
    .ahb_burst_out(ahb_burst_out), .ahb_size_out(ahb_size_out),
    .ahb_write_out(ahb_write_out), .ahb_wdata_out(ahb_wdata_out),
    .ahb_rdata_in(ahb_rdata_in), .ahb_ready_in(ahb_ready_in),
    .ahb_resp_in(ahb_resp_in)
  );

  always #5 ahb_clk_in = ~ahb_clk_in;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    int          wait_beat;
    int          waits;
    int          err_beat;
    int          exp_aph;
    int          exp_beats;
    logic        exp_done;
    logic        exp_err;
    logic        exp_reject;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rd_q[$];
  logic [31:0] obs_addr[16];
  vec_t        vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int burst_beats(input logic [2:0] b);
    if (b < 3'd2) return 1;
    if (b < 3'd4) return 4;
    if (b < 3'd6) return 8;
    return 16;
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [2:0] size,
                                             input logic [2:0] burst, input int i);
    int unsigned step, total, base;
    step  = 32'd1 << size;
    total = 32'(burst_beats(burst)) * step;
    if (burst == 3'd2 || burst == 3'd4 || burst == 3'd6) begin
      base = a - (a % total);
      return base + ((a - base + 32'(i) * step) % total);
    end
    return a + 32'(i) * step;
  endfunction

  function automatic logic [31:0] wdata_fn(input int b);
    return 32'hDEADBEEF + 32'h01010101 * 32'(b);
  endfunction

  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, " addr"},   64'(ahb_addr_out),    64'd0);
    check({tag, " trans"},  64'(ahb_trans_out),   64'(T_IDLE));
    check({tag, " wdata"},  64'(ahb_wdata_out),   64'd0);
    check({tag, " size"},   64'(ahb_size_out),    64'd0);
    check({tag, " burst"},  64'(ahb_burst_out),   64'd0);
    check({tag, " write"},  64'(ahb_write_out),   64'd0);
    check({tag, " rdata"},  64'(rdata_out),       64'd0);
    check({tag, " cready"}, 64'(cmd_ready_out),   64'd0);
    check({tag, " wready"}, 64'(wdata_ready_out), 64'd0);
    check({tag, " rvalid"}, 64'(rdata_valid_out), 64'd0);
    check({tag, " done"},   64'(done_out),        64'd0);
    check({tag, " error"},  64'(error_out),       64'd0);
  endtask

  // Issue one command and play the slave until it finishes plus a few idle cycles
  task automatic run_vec(input vec_t v, input int id);
    int aph = 0, beats_ok = 0, dp_beat = 0, waits_left, err_cyc = 0;
    int n_done = 0, n_err = 0, n_rv = 0, err_at = -1, tail = 0;
    logic dp_active = 1'b0, finished = 1'b0, rdy, rsp;
    logic [31:0] dp_addr = '0;
    string tg;
    tg = $sformatf("v%0d", id);
    waits_left = v.waits;
    exp_rd_q.delete();
    if (!v.write)
      for (int i = 0; i < v.exp_beats; i++)
        exp_rd_q.push_back(rdata_fn(model_addr(v.addr, v.size, v.burst, i)));
    @(negedge ahb_clk_in);
    cmd_addr_in  = v.addr;
    cmd_write_in = v.write;
    cmd_size_in  = v.size;
    cmd_burst_in = v.burst;
    cmd_valid_in = 1'b1;
    ahb_ready_in = 1'b1;
    ahb_resp_in  = 1'b0;
    check({tg, " cmd_ready"}, 64'(cmd_ready_out), 64'd1);
    @(posedge ahb_clk_in);
    @(negedge ahb_clk_in);
    cmd_valid_in = 1'b0;
    for (int cyc = 0; cyc < 200 && tail < 3; cyc++) begin
      if (rdata_valid_out) begin
        n_rv++;
        if (exp_rd_q.size() == 0) check({tg, " rvalid_extra"}, 64'd1, 64'd0);
        else check({tg, " rdata"}, 64'(rdata_out), 64'(exp_rd_q.pop_front()));
      end
      if (done_out) n_done++;
      if (error_out) begin
        n_err++;
        if (err_at < 0) err_at = cyc;
      end
      if (finished) tail++;
      if (done_out || error_out) finished = 1'b1;
      rdy = 1'b1;
      rsp = 1'b0;
      if (dp_active) begin
        if (dp_beat == v.err_beat) begin
          if (err_cyc == 0) begin
            rdy = 1'b0; rsp = 1'b1; err_cyc = 1;
          end else begin
            rdy = 1'b1; rsp = 1'b1; err_cyc = 2;
            check({tg, " htrans_cancel"}, 64'(ahb_trans_out), 64'(T_IDLE));
          end
        end else if (dp_beat == v.wait_beat && waits_left > 0) begin
          rdy = 1'b0;
          waits_left--;
        end
      end
      ahb_ready_in = rdy;
      ahb_resp_in  = rsp;
      ahb_rdata_in = rdata_fn(dp_addr);
      wdata_in     = wdata_fn(aph);
      #1;
      if (dp_active && rdy && !rsp) begin
        beats_ok++;
        if (v.write) check({tg, " hwdata"}, 64'(ahb_wdata_out), 64'(wdata_fn(dp_beat)));
      end
      if (dp_active && rdy) dp_active = 1'b0;
      if (ahb_trans_out == T_NONSEQ || ahb_trans_out == T_SEQ) begin
        check({tg, " htrans"}, 64'(ahb_trans_out), 64'((aph == 0) ? T_NONSEQ : T_SEQ));
        check({tg, " haddr"}, 64'(ahb_addr_out), 64'(model_addr(v.addr, v.size, v.burst, aph)));
        check({tg, " ctrl"}, 64'({ahb_write_out, ahb_size_out, ahb_burst_out}),
              64'({v.write, v.size, v.burst}));
        check({tg, " wready"}, 64'(wdata_ready_out), 64'(v.write && rdy));
        if (rdy) begin
          if (aph < 16) obs_addr[aph] = ahb_addr_out;
          dp_active = 1'b1;
          dp_beat   = aph;
          dp_addr   = ahb_addr_out;
          aph++;
        end
      end else begin
        check({tg, " htrans_idle"}, 64'(ahb_trans_out), 64'(T_IDLE));
      end
      @(posedge ahb_clk_in);
      @(negedge ahb_clk_in);
    end
    check({tg, " finished"}, 64'(finished && tail >= 3), 64'd1);
    check({tg, " n_done"}, 64'(n_done), 64'(v.exp_done));
    check({tg, " n_error"}, 64'(n_err), 64'(v.exp_err));
    check({tg, " n_addr_phases"}, 64'(aph), 64'(v.exp_aph));
    check({tg, " n_data_beats"}, 64'(beats_ok), 64'(v.exp_beats));
    check({tg, " n_rvalid"}, 64'(n_rv), 64'(v.write ? 0 : v.exp_beats));
    check({tg, " rd_queue_left"}, 64'(exp_rd_q.size()), 64'd0);
    check({tg, " cmd_ready_end"}, 64'(cmd_ready_out), 64'd1);
    if (v.exp_reject) check({tg, " reject_latency"}, 64'(err_at), 64'd0);
  endtask

  initial begin
    logic [31:0] wrap_exp[4];
    vec_t wrap4;
    //          addr      wr    sz    bst   wbt wt  ebt aph bts dn    er    rej
    vecs[0]  = '{32'h100, 1'b1, 3'd2, 3'd0, -1, 0, -1,  1,  1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h200, 1'b0, 3'd2, 3'd3,  1, 2, -1,  4,  4, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h400, 1'b1, 3'd2, 3'd5, -1, 0,  2,  3,  2, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'h100, 1'b0, 3'd3, 3'd0, -1, 0, -1,  0,  0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{32'h102, 1'b0, 3'd2, 3'd0, -1, 0, -1,  0,  0, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{32'h3F0, 1'b0, 3'd2, 3'd7, -1, 0, -1,  0,  0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{32'h01C, 1'b1, 3'd1, 3'd4,  3, 1, -1,  8,  8, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h080, 1'b0, 3'd0, 3'd1,  0, 1, -1,  1,  1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'h3FC, 1'b0, 3'd2, 3'd6, -1, 0, -1, 16, 16, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h040, 1'b0, 3'd2, 3'd0, -1, 0,  0,  1,  0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{32'h3C0, 1'b1, 3'd2, 3'd7, 15, 1, -1, 16, 16, 1'b1, 1'b0, 1'b0};
    wrap4    = '{32'h038, 1'b0, 3'd2, 3'd2, -1, 0, -1,  4,  4, 1'b1, 1'b0, 1'b0};
    wrap_exp = '{32'h38, 32'h3C, 32'h30, 32'h34};

    #2;
    check_reset_vals("por");
    @(negedge ahb_clk_in);
    ahb_rstn_in = 1'b1;
    @(posedge ahb_clk_in);
    @(negedge ahb_clk_in);
    check("por cmd_ready_after_release", 64'(cmd_ready_out), 64'd1);

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], i);
      if (i == 1)
        for (int k = 0; k < 4; k++)
          check($sformatf("incr4 addr%0d", k), 64'(obs_addr[k]), 64'(32'h200 + 32'(4 * k)));
    end

    run_vec(wrap4, 20);
    for (int k = 0; k < 4; k++)
      check($sformatf("wrap4 addr%0d", k), 64'(obs_addr[k]), 64'(wrap_exp[k]));

    // Reset while beat 2 of an INCR16 read is in its address phase
    @(negedge ahb_clk_in);
    cmd_addr_in  = 32'h0;
    cmd_write_in = 1'b0;
    cmd_size_in  = 3'd2;
    cmd_burst_in = 3'd7;
    cmd_valid_in = 1'b1;
    ahb_ready_in = 1'b1;
    @(posedge ahb_clk_in);
    @(negedge ahb_clk_in);
    cmd_valid_in = 1'b0;
    check("rst16 nonseq", 64'(ahb_trans_out), 64'(T_NONSEQ));
    @(posedge ahb_clk_in);
    @(negedge ahb_clk_in);
    check("rst16 seq", 64'(ahb_trans_out), 64'(T_SEQ));
    check("rst16 addr2", 64'(ahb_addr_out), 64'h4);
    ahb_ready_in = 1'b0;
    #1;
    ahb_rstn_in = 1'b0;
    #1;
    check_reset_vals("mid");
    @(posedge ahb_clk_in);
    @(posedge ahb_clk_in);
    @(negedge ahb_clk_in);
    check_reset_vals("held");
    ahb_rstn_in  = 1'b1;
    ahb_ready_in = 1'b1;
    @(posedge ahb_clk_in);
    @(negedge ahb_clk_in);
    check("rel cmd_ready", 64'(cmd_ready_out), 64'd1);
    check("rel trans", 64'(ahb_trans_out), 64'(T_IDLE));
    check("rel done_err", 64'({done_out, error_out}), 64'd0);
    run_vec(vecs[1], 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, 1 expected");
    $fatal(1);
  end

endmodule
